// File: rtl/updown_display_counter.sv
// Multi-digit BCD/hex up/down counter with prescaled count enable and a scanned, active-low 7-segment driver.
// Count and wrap_pulse land on the tick edge, seg/digit_sel lag scan index and value by one cycle; no backpressure.
module updown_display_counter #(
  parameter int DIGITS   = 4,
  parameter int HEX      = 0,
  parameter int SATURATE = 0,
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap_pulse,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [3:0]    DMAX      = (HEX != 0) ? 4'hF : 4'h9;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b1111111;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------- prescaler
  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == TICK_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // ---------------------------------------------------------------- counter
  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] load_clamped;
  logic [3:0]          cur_d;
  logic                carry;
  logic                all_max;
  logic                all_zero;
  logic                at_bound;

  // Ripple carry/borrow across digits; a full roll-over yields 0 (up) or all-max (down).
  always_comb begin
    step_val     = value;
    load_clamped = load_value;
    cur_d        = 4'h0;
    carry        = 1'b1;
    all_max      = 1'b1;
    all_zero     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      cur_d    = value[4*i +: 4];
      all_max  = all_max  & (cur_d == DMAX);
      all_zero = all_zero & (cur_d == 4'h0);
      if (carry) begin
        if (up_down) begin
          if (cur_d == DMAX) begin
            step_val[4*i +: 4] = 4'h0;
          end else begin
            step_val[4*i +: 4] = cur_d + 4'h1;
            carry = 1'b0;
          end
        end else begin
          if (cur_d == 4'h0) begin
            step_val[4*i +: 4] = DMAX;
          end else begin
            step_val[4*i +: 4] = cur_d - 4'h1;
            carry = 1'b0;
          end
        end
      end
      if ((HEX == 0) && (load_value[4*i +: 4] > 4'h9)) begin
        load_clamped[4*i +: 4] = 4'h9;
      end
    end
    at_bound = up_down ? all_max : all_zero;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value      <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (load) begin
        value <= load_clamped;
      end else if (tick && enable) begin
        if (!(at_bound && (SATURATE != 0))) begin
          value      <= step_val;
          wrap_pulse <= at_bound;
        end
      end
    end
  end

  // ---------------------------------------------------------------- scan
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  logic [3:0]        shown_digit;
  logic [DIGITS-1:0] sel_next;

  always_comb begin
    shown_digit = 4'h0;
    sel_next    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IW'(i)) begin
        shown_digit = value[4*i +: 4];
        sel_next[i] = 1'b0;
      end
    end
  end

  // Registered so both display buses switch on the same edge and never overlap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg       <= 7'b1111111;
      digit_sel <= '1;
    end else begin
      seg       <= seg_decode(shown_digit);
      digit_sel <= sel_next;
    end
  end

endmodule

// File: doc/updown_display_counter.md
# updown_display_counter

Parametrised multi-digit up/down counter with an integrated count-enable prescaler and a time-multiplexed, active-low seven-segment driver. The count state and the digit scan both live in the single `clock` domain, with no derived clocks. Each digit is BCD or hex, selected by parameter. The block drives a bank of common-anode displays directly and replaces the single-digit free-running counter in board-level lab tops.

## Interface
- `DIGITS`, default 4: number of 4-bit digits, range 1..8.
- `HEX`, default 0: 0 means each digit counts 0..9 (BCD); 1 means each digit counts 0..F.
- `SATURATE`, default 0: 0 means wrap at the bounds; 1 means hold at the bounds.
- `TICK_DIV`, default 50000000: `clock` cycles per count step, minimum 2.
- `SCAN_DIV`, default 50000: `clock` cycles per digit scan slot, minimum 2.

- `clock` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-low.
- `enable` in 1: gates count steps.
- `up_down` in 1: 1 counts up, 0 counts down.
- `load` in 1: synchronous load strobe.
- `load_value` in 4*DIGITS: value to load, digit 0 in bits [3:0].
- `value` out 4*DIGITS: current count, digit 0 least significant.
- `wrap_pulse` out 1: one-cycle pulse when the count wraps.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `digit_sel` out DIGITS: digit enables, one-hot, active-low.

## Operation
- **Reset (asynchronous, immediate):**
  - `value` = 0, `wrap_pulse` = 0.
  - Prescaler = 0, scan counter = 0, scan index = 0.
  - `seg` = 7'b1111111, `digit_sel` = all ones (display blank).
- **Prescaler:**
  - Free-runs 0..TICK_DIV-1 regardless of `enable` and `load`.
  - Internal `tick` is high for the single cycle where the prescaler equals TICK_DIV-1.
- **Priority at each edge:** `load` > (`tick` && `enable`) > hold.
- **Load:**
  - `value` <= `load_value`.
  - When HEX=0, any digit > 9 is loaded as 9.
  - No `wrap_pulse`.
- **Step up:**
  - Digit 0 increments.
  - A digit at its maximum (9 or F) rolls to 0 and carries into the next digit.
  - All digits at maximum is the upper bound. With SATURATE=0 the value becomes 0 and `wrap_pulse` = 1 for one cycle. With SATURATE=1 the value is held and there is no pulse.
- **Step down:**
  - Digit 0 decrements.
  - A digit at 0 becomes its maximum and borrows from the next digit.
  - All-zero is the lower bound. With SATURATE=0 the value becomes all-max and `wrap_pulse` fires. With SATURATE=1 the value is held and there is no pulse.
- **`up_down` timing:** sampled on the tick edge only; changing it between ticks has no effect.
- **Scan:**
  - The scan counter runs 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the scan index advances, wrapping from DIGITS-1 to 0.
- **Display outputs (registered every cycle):**
  - `digit_sel` <= ~(1 << index).
  - `seg` <= decode(digit[index]) of the current `value`.
- **Decode (active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Invalid BCD:** values 10..15 are unreachable when HEX=0; the decoder still maps them per the list above.

## Timing
- **Count latency:** `value` changes on the edge where `tick` && `enable` is 1. `wrap_pulse` is registered and is high during the cycle that follows that edge.
- **Step period:** with `enable` held high, steps occur exactly every TICK_DIV cycles. The first step is at cycle TICK_DIV after reset release.
- **Load latency:** visible on `value` one edge after the `load` cycle.
  - `load` in a tick cycle suppresses that step.
  - The prescaler phase is unaffected.
- **Display latency:** `seg`/`digit_sel` lag the index and `value` by one cycle.
  - The first non-blank output appears after the first edge following reset release, showing digit 0.
  - Each digit is held for SCAN_DIV cycles; the full refresh period is DIGITS*SCAN_DIV.
- **Reset mid-operation:** all state clears immediately. The counting and scan sequences restart from zero.
- **Glitch-free enables:** `digit_sel` never has more than one bit low.

## Test plan
- DIGITS=2, HEX=0, TICK_DIV=4, `enable`=1, `up_down`=1 from reset -> `value` steps 00,01,…,09,10 every 4 cycles; 99 -> 00 with `wrap_pulse` high exactly one cycle.
- Same config with `up_down`=0 -> 00 -> 99 with `wrap_pulse`; then 90 -> 89 (borrow); with SATURATE=1, 00 holds and there is no pulse.
- HEX=1, `load` 0xFE, count up -> FF, then 00 with pulse; `load` in the same cycle as a tick -> only the loaded value appears, no step.
- HEX=0, `load` 0xA7 -> `value` = 0x97; `enable`=0 for 3 tick periods -> `value` frozen, prescaler continues, stepping resumes on the next tick.
- DIGITS=4, SCAN_DIV=2, `value` 0x1234 -> `digit_sel` cycles 1110,1101,1011,0111 every 2 cycles with `seg` 0011001,0110000,0100100,1111001, one-cycle lag.
- Assert `reset` mid-count and mid-scan -> `seg`=1111111, `digit_sel`=all ones, `value`=0 immediately; on release, the first step occurs TICK_DIV cycles later.
